// File: rtl/inst_fetcher.sv
// inst_fetcher: byte-serial instruction fetch engine.
// Issues four byte reads per instruction on the shared RAM bus, yields to the
// data side while i_bus_busy is high, and returns the little-endian word with its PC.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.

`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif

module inst_fetcher (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fetch_req,
    input  logic [`InstAddrBus] i_fetch_pc,
    input  logic                i_flush,
    input  logic                i_bus_busy,
    input  logic [7:0]          i_mem_din,
    output logic [`InstAddrBus] o_mem_a,
    output logic                o_mem_rd,
    output logic [`InstBus]     o_inst_out,
    output logic [`InstAddrBus] o_pc_back,
    output logic                o_inst_valid,
    output logic                o_inst_almost_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              r_state, w_state_nx;
    logic [`InstAddrBus] r_pc, w_pc_nx;
    logic [`InstAddrBus] r_mem_a, w_mem_a_nx;
    logic                r_mem_rd, w_mem_rd_nx;
    logic [1:0]          r_cnt, w_cnt_nx;      // next byte index to issue
    logic [1:0]          r_lane, w_lane_nx;    // byte index of the read on the bus
    logic                r_rd_d;               // RAM sampled a fetch read last edge
    logic [1:0]          r_lane_d;             // lane that read's data belongs to
    logic [3:0][7:0]     r_bytes;
    logic [`InstBus]     r_inst_out, w_inst_nx;
    logic [`InstAddrBus] r_pc_back, w_pcb_nx;
    logic                r_inst_valid, w_valid_nx;
    logic                w_accept;
    logic                w_cap_last;
    logic [`InstBus]     w_asm;
    logic                w_hit;
    logic [`InstBus]     w_hit_data;

    // last byte arrives straight from RAM; lanes 0..2 are already captured
    assign w_cap_last = r_rd_d && (r_lane_d == 2'd3);
    assign w_asm      = {i_mem_din, r_bytes[2], r_bytes[1], r_bytes[0]};

`ifdef ICACHE_EN
    logic [`InstBus] r_cdata [0:31];
    logic [10:0]     r_ctag  [0:31];
    logic [31:0]     r_cvalid;
    logic            w_fill;

    assign w_hit      = r_cvalid[i_fetch_pc[6:2]] && (r_ctag[i_fetch_pc[6:2]] == i_fetch_pc[17:7]);
    assign w_hit_data = r_cdata[i_fetch_pc[6:2]];

    // valid bits: cleared by reset only, set when a miss completes
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cvalid <= '0;
        else if (w_fill)
            r_cvalid[r_pc[6:2]] <= 1'b1;
    end

    // tag/data storage written on miss completion
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_cdata[r_pc[6:2]] <= w_asm;
            r_ctag[r_pc[6:2]]  <= r_pc[17:7];
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // next state and next values of the bus/result registers
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_mem_a_nx  = r_mem_a;
        w_mem_rd_nx = 1'b0;
        w_cnt_nx    = r_cnt;
        w_lane_nx   = r_lane;
        w_valid_nx  = 1'b0;
        w_inst_nx   = r_inst_out;
        w_pcb_nx    = r_pc_back;
        w_accept    = 1'b0;
`ifdef ICACHE_EN
        w_fill      = 1'b0;
`endif
        if (i_flush) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_fetch_req) begin
                        if (w_hit) begin
                            w_valid_nx = 1'b1;
                            w_inst_nx  = w_hit_data;
                            w_pcb_nx   = i_fetch_pc;
                        end else if (!i_bus_busy) begin
                            w_accept = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!i_bus_busy) begin
                        w_mem_a_nx  = r_pc + {30'd0, r_cnt};
                        w_mem_rd_nx = 1'b1;
                        w_lane_nx   = r_cnt;
                        w_cnt_nx    = r_cnt + 2'd1;
                        if (r_cnt == 2'd3)
                            w_state_nx = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_cap_last) begin
                        w_valid_nx = 1'b1;
                        w_inst_nx  = w_asm;
                        w_pcb_nx   = r_pc;
                        w_state_nx = S_IDLE;
`ifdef ICACHE_EN
                        w_fill     = 1'b1;
`endif
                        if (i_fetch_req && !i_bus_busy)
                            w_accept = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
            if (w_accept) begin
                w_pc_nx     = i_fetch_pc;
                w_mem_a_nx  = i_fetch_pc;
                w_mem_rd_nx = 1'b1;
                w_lane_nx   = 2'd0;
                w_cnt_nx    = 2'd1;
                w_state_nx  = S_ISSUE;
            end
        end
    end

    // bus and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= '0;
            r_mem_a      <= '0;
            r_mem_rd     <= 1'b0;
            r_cnt        <= 2'd0;
            r_lane       <= 2'd0;
            r_inst_out   <= '0;
            r_pc_back    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_nx;
            r_mem_a      <= w_mem_a_nx;
            r_mem_rd     <= w_mem_rd_nx;
            r_cnt        <= w_cnt_nx;
            r_lane       <= w_lane_nx;
            r_inst_out   <= w_inst_nx;
            r_pc_back    <= w_pcb_nx;
            r_inst_valid <= w_valid_nx;
        end
    end

    // read-return pipeline: data of a read shows up two edges after issue;
    // a flush kills any byte still in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_d   <= 1'b0;
            r_lane_d <= 2'd0;
            r_bytes  <= '0;
        end else begin
            r_rd_d   <= r_mem_rd && !i_flush;
            r_lane_d <= r_lane;
            if (r_rd_d && !i_flush)
                r_bytes[r_lane_d] <= i_mem_din;
        end
    end

    assign o_mem_a             = r_mem_a;
    assign o_mem_rd            = r_mem_rd;
    assign o_inst_out          = r_inst_out;
    assign o_pc_back           = r_pc_back;
    assign o_inst_valid        = r_inst_valid;
    assign o_inst_almost_valid = r_mem_rd && (r_mem_a == r_pc + 32'd3);

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a registered byte-wide RAM model.
// Cache-specific checks are compiled only when ICACHE_EN is defined.
`timescale 1ns/1ps

module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst, fetch_req, flush, bus_busy;
    logic [31:0] fetch_pc;
    logic [7:0]  mem_din;
    logic [31:0] mem_a, inst_out, pc_back;
    logic        mem_rd, inst_valid, almost;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req), .i_fetch_pc(fetch_pc),
        .i_flush(flush), .i_bus_busy(bus_busy), .i_mem_din(mem_din),
        .o_mem_a(mem_a), .o_mem_rd(mem_rd), .o_inst_out(inst_out),
        .o_pc_back(pc_back), .o_inst_valid(inst_valid),
        .o_inst_almost_valid(almost)
    );

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;  32'h101: return 8'h05;
            32'h102: return 8'hA0;  32'h103: return 8'h00;
            32'h104: return 8'h93;  32'h105: return 8'h00;
            32'h106: return 8'h10;  32'h107: return 8'h00;
            32'h300: return 8'h33;  32'h301: return 8'h01;
            32'h302: return 8'h00;  32'h303: return 8'h00;
            32'h20100: return 8'hB7; 32'h20101: return 8'h12;
            32'h20102: return 8'h00; 32'h20103: return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM: data reflects the address sampled at the previous edge
    always @(posedge clk) mem_din <= ram_byte(mem_a);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; bus_busy = 1'b0; fetch_pc = '0;
        tick();
        rst = 1'b0;
    endtask

    // ticks until inst_valid; returns edges counted after the accept edge, -1 on timeout
    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (inst_valid) begin
                n = i;
                break;
            end
        end
    endtask

    // plain miss fetch from idle: request, accept edge, wait for result
    task automatic miss_fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        int n;
        fetch_req = 1'b1; fetch_pc = pc;
        tick();
        fetch_req = 1'b0;
        wait_valid(20, n);
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_inst"}, inst_out, exp);
        chk({tag, "_pc"}, pc_back, pc);
    endtask

    initial begin
        mem_din = '0;
        do_reset();
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pcb", pc_back, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_almost", almost, 0);

        // basic miss: addresses 0x100..0x103 after edges 0..3
        fetch_req = 1'b1; fetch_pc = 32'h100;
        tick();
        fetch_req = 1'b0;
        chk("b_a0", mem_a, 32'h100); chk("b_rd0", mem_rd, 1); chk("b_av0", almost, 0);
        tick(); chk("b_a1", mem_a, 32'h101);
        tick(); chk("b_a2", mem_a, 32'h102); chk("b_av2", almost, 0);
        tick(); chk("b_a3", mem_a, 32'h103); chk("b_av3", almost, 1);
        tick(); chk("b_rd4", mem_rd, 0); chk("b_v4", inst_valid, 0);
        tick(); chk("b_v5", inst_valid, 1);
        chk("b_inst", inst_out, 32'h00A00513); chk("b_pcb", pc_back, 32'h100);
        tick(); chk("b_v6", inst_valid, 0);

        // bus_busy sampled at edges 2 and 3
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h100;
        tick(); fetch_req = 1'b0; chk("bb_rd0", mem_rd, 1);
        tick(); chk("bb_rd1", mem_rd, 1); bus_busy = 1'b1;
        tick(); chk("bb_rd2", mem_rd, 0);
        tick(); chk("bb_rd3", mem_rd, 0); bus_busy = 1'b0;
        tick(); chk("bb_rd4", mem_rd, 1); chk("bb_a4", mem_a, 32'h102);
        tick(); chk("bb_a5", mem_a, 32'h103); chk("bb_av5", almost, 1);
        tick(); chk("bb_v6", inst_valid, 0);
        tick(); chk("bb_v7", inst_valid, 1); chk("bb_inst", inst_out, 32'h00A00513);

        // flush at edge 2 of fetch 0x200 with request for 0x300 held
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h200;
        tick(); fetch_pc = 32'h300;
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        chk("fl_rd2", mem_rd, 0); chk("fl_v2", inst_valid, 0);
        tick(); fetch_req = 1'b0;
        chk("fl_a3", mem_a, 32'h300); chk("fl_rd3", mem_rd, 1);
        wait_valid(20, lat);
        chk("fl_lat", lat, 5);
        chk("fl_inst", inst_out, 32'h00000133); chk("fl_pcb", pc_back, 32'h300);

        // back-to-back 0x100 then 0x104
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h100;
        tick(); fetch_pc = 32'h104;
        wait_valid(20, lat);
        fetch_req = 1'b0;
        chk("bt_lat1", lat, 5); chk("bt_pcb1", pc_back, 32'h100);
        chk("bt_a", mem_a, 32'h104); chk("bt_rd", mem_rd, 1);
        wait_valid(20, lat);
        chk("bt_lat2", lat, 5);
        chk("bt_inst2", inst_out, 32'h00100093); chk("bt_pcb2", pc_back, 32'h104);

        // top of address space
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'hFFFF_FFFC;
        tick(); fetch_req = 1'b0;
        tick(); tick(); tick();
        chk("top_a3", mem_a, 32'hFFFF_FFFF); chk("top_av3", almost, 1);
        wait_valid(20, lat);
        chk("top_lat", lat, 2); chk("top_inst", inst_out, 32'hA5A4A7A6);

        // reset mid-fetch, then a clean fetch
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h104;
        tick(); fetch_req = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("mr_a", mem_a, 0); chk("mr_rd", mem_rd, 0); chk("mr_av", almost, 0);
        chk("mr_inst", inst_out, 0); chk("mr_pcb", pc_back, 0); chk("mr_v", inst_valid, 0);
        tick();
        miss_fetch("mr_f", 32'h100, 32'h00A00513);

`ifdef ICACHE_EN
        do_reset();
        miss_fetch("c_miss", 32'h100, 32'h00A00513);
        tick();
        fetch_req = 1'b1; fetch_pc = 32'h100;
        tick(); fetch_req = 1'b0;
        chk("c_hit_v", inst_valid, 1); chk("c_hit_rd", mem_rd, 0);
        chk("c_hit_inst", inst_out, 32'h00A00513); chk("c_hit_pcb", pc_back, 32'h100);
        tick(); chk("c_hit_v1", inst_valid, 0); chk("c_hit_rd1", mem_rd, 0);
        miss_fetch("c_alias", 32'h20100, 32'h000012B7);
        tick();
        miss_fetch("c_evict", 32'h100, 32'h00A00513);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
